// File: rtl/pu_msp430_ram_pkg.sv
// Shared types and decode helpers for the MSP430 data-RAM arbiter.
// Keeps owner tags, the read-enable code and byte-to-word decode in one place.
package pu_msp430_ram_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned WE_W   = 2;

    localparam logic [WE_W-1:0] WE_READ = 2'b00;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DMA  = 2'd2
    } owner_t;

    // Payload of whichever master wins the RAM port this cycle.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [WE_W-1:0]   we;
        logic [DATA_W-1:0] wdata;
    } mreq_t;

    // Byte offset of an address relative to the RAM window base.
    function automatic logic [ADDR_W-1:0] byte_off(input logic [ADDR_W-1:0] addr,
                                                   input logic [ADDR_W-1:0] base);
        return addr - base;
    endfunction

    // True when the address falls inside [base, base + size).
    function automatic logic in_range(input logic [ADDR_W-1:0] addr,
                                      input logic [ADDR_W-1:0] off,
                                      input logic [ADDR_W-1:0] base,
                                      input logic [ADDR_W:0]   size);
        return (addr >= base) && ({1'b0, off} < size);
    endfunction

endpackage

// File: rtl/pu_msp430_ram_arb_if.sv
// Bus bundle between the CPU/DMA masters, the arbiter and the single-port data RAM.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface pu_msp430_ram_arb_if #(
    parameter int unsigned ADDR_MSB = 6
);
    import pu_msp430_ram_pkg::*;

    logic              cpu_req;
    logic [ADDR_W-1:0] cpu_addr;
    logic [WE_W-1:0]   cpu_we;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    logic              dma_req;
    logic [ADDR_W-1:0] dma_addr;
    logic [WE_W-1:0]   dma_we;
    logic [DATA_W-1:0] dma_wdata;
    logic              dma_gnt;
    logic              dma_rvalid;
    logic [DATA_W-1:0] dma_rdata;

    logic              acc_err;

    logic [ADDR_MSB:0] ram_addr;
    logic              ram_cen;
    logic [WE_W-1:0]   ram_wen;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout;

    modport slave (
        input  cpu_req, cpu_addr, cpu_we, cpu_wdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        input  dma_req, dma_addr, dma_we, dma_wdata,
        output dma_gnt, dma_rvalid, dma_rdata,
        output acc_err,
        output ram_addr, ram_cen, ram_wen, ram_din,
        input  ram_dout
    );

    modport master (
        output cpu_req, cpu_addr, cpu_we, cpu_wdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        output dma_req, dma_addr, dma_we, dma_wdata,
        input  dma_gnt, dma_rvalid, dma_rdata,
        input  acc_err,
        input  ram_addr, ram_cen, ram_wen, ram_din,
        output ram_dout
    );

endinterface

// File: rtl/pu_msp430_ram_arb_core.sv
// Grant logic for the CPU/DMA RAM port: CPU normally wins, but a DMA request
// that has been stalled DMA_MAX_WAIT cycles is forced through.
module pu_msp430_ram_arb_core #(
    parameter int unsigned DMA_MAX_WAIT = 3
) (
    input  logic mclk,
    input  logic reset_n,
    input  logic cpu_req,
    input  logic dma_req,
    output logic cpu_gnt,
    output logic dma_gnt
);

    localparam int unsigned WCNT_W = (DMA_MAX_WAIT < 1) ? 1 : $clog2(DMA_MAX_WAIT + 1);
    localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(DMA_MAX_WAIT);

    logic [WCNT_W-1:0] wait_cnt;
    logic [WCNT_W-1:0] wait_cnt_nxt;
    logic              dma_force;
    logic              dma_stall;

    // Grants are masked while in reset so nothing reaches the RAM.
    always_comb begin
        dma_force    = (wait_cnt == WCNT_MAX);
        dma_gnt      = reset_n & dma_req & (~cpu_req | dma_force);
        cpu_gnt      = reset_n & cpu_req & ~dma_gnt;
        dma_stall    = dma_req & ~dma_gnt;
        wait_cnt_nxt = '0;
        if (dma_stall) begin
            wait_cnt_nxt = dma_force ? wait_cnt : wait_cnt + WCNT_W'(1);
        end
    end

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt_nxt;
        end
    end

endmodule

// File: rtl/pu_msp430_ram_arb.sv
// Two-master arbiter and byte-to-word decoder in front of the single-port data RAM.
// Routes the one-cycle-latency read data back to whichever master issued the read.
module pu_msp430_ram_arb
    import pu_msp430_ram_pkg::*;
#(
    parameter int unsigned       ADDR_MSB     = 6,
    parameter int unsigned       MEM_SIZE     = 256,
    parameter logic [ADDR_W-1:0] RAM_BASE     = 16'h0200,
    parameter int unsigned       DMA_MAX_WAIT = 3
) (
    input  logic              mclk,
    input  logic              reset_n,
    pu_msp430_ram_arb_if.slave bus
);

    logic              cpu_gnt;
    logic              dma_gnt;
    logic              any_gnt;
    mreq_t             win;
    owner_t            win_owner;
    logic [ADDR_W-1:0] win_off;
    logic              win_in_range;
    logic              win_read;

    owner_t            rd_owner;
    logic              rd_in_range;
    logic              acc_err_q;
    logic              cpu_rvalid;
    logic              dma_rvalid;

    pu_msp430_ram_arb_core #(
        .DMA_MAX_WAIT (DMA_MAX_WAIT)
    ) u_core (
        .mclk    (mclk),
        .reset_n (reset_n),
        .cpu_req (bus.cpu_req),
        .dma_req (bus.dma_req),
        .cpu_gnt (cpu_gnt),
        .dma_gnt (dma_gnt)
    );

    // Winner select and decode; with no winner the CPU side shows through.
    always_comb begin
        any_gnt      = cpu_gnt | dma_gnt;
        win          = dma_gnt ? {bus.dma_addr, bus.dma_we, bus.dma_wdata}
                               : {bus.cpu_addr, bus.cpu_we, bus.cpu_wdata};
        win_owner    = OWN_NONE;
        if (dma_gnt) begin
            win_owner = OWN_DMA;
        end else if (cpu_gnt) begin
            win_owner = OWN_CPU;
        end
        win_off      = byte_off(win.addr, RAM_BASE);
        win_in_range = in_range(win.addr, win_off, RAM_BASE, (ADDR_W+1)'(MEM_SIZE));
        win_read     = any_gnt & (win.we == WE_READ);
    end

    assign bus.cpu_gnt  = cpu_gnt;
    assign bus.dma_gnt  = dma_gnt;
    assign bus.ram_cen  = ~(any_gnt & win_in_range);
    assign bus.ram_wen  = any_gnt ? ~win.we : 2'b11;
    assign bus.ram_addr = win_off[ADDR_MSB+1:1];
    assign bus.ram_din  = win.wdata;

    // Read-return pipeline: tag each read with its owner for the RAM's one-cycle latency.
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            rd_owner    <= OWN_NONE;
            rd_in_range <= 1'b0;
            acc_err_q   <= 1'b0;
        end else begin
            rd_owner    <= win_read ? win_owner : OWN_NONE;
            rd_in_range <= win_in_range;
            acc_err_q   <= any_gnt & ~win_in_range;
        end
    end

    assign cpu_rvalid     = (rd_owner == OWN_CPU);
    assign dma_rvalid     = (rd_owner == OWN_DMA);
    assign bus.cpu_rvalid = cpu_rvalid;
    assign bus.dma_rvalid = dma_rvalid;
    assign bus.acc_err    = acc_err_q;

    // Out-of-range reads return zero rather than whatever the idle RAM is holding.
    assign bus.cpu_rdata  = (cpu_rvalid && rd_in_range) ? bus.ram_dout : '0;
    assign bus.dma_rdata  = (dma_rvalid && rd_in_range) ? bus.ram_dout : '0;

endmodule

// File: doc/pu_msp430_ram_arb.md
Name: pu_msp430_ram_arb

Overview:
- Two-master arbiter and address decoder that sits directly upstream of the single-port data RAM.
- Merges the CPU data-memory port and the DMA port onto one RAM port and translates byte addresses to word addresses.
- Converts active-high byte enables into the RAM's active-low chip enable and write enables.
- Returns read data to the owning master with the RAM's one-cycle read latency. Guarantees DMA forward progress with a starvation counter.

Parameters:
- ADDR_MSB, 6: MSB of the RAM word address.
- MEM_SIZE, 256: RAM size in bytes.
- RAM_BASE, 16'h0200: byte address of RAM word 0.
- DMA_MAX_WAIT, 3: stalled DMA cycles before DMA is forced to win; 0 means DMA always wins when requesting.

Ports:
- mclk  in  1  system clock; also clocks the RAM.
- reset_n  in  1  asynchronous active-low reset.
- cpu_req  in  1  CPU access request; held until granted.
- cpu_addr  in  16  CPU byte address; bit 0 is ignored.
- cpu_we  in  2  CPU byte write enables, active high; [1]=high byte, 00=read.
- cpu_wdata  in  16  CPU write data.
- cpu_gnt  out  1  CPU request accepted this cycle (combinational).
- cpu_rvalid  out  1  CPU read data valid.
- cpu_rdata  out  16  CPU read data.
- dma_req, dma_addr, dma_we, dma_wdata, dma_gnt, dma_rvalid, dma_rdata: same as the CPU set, for the DMA master.
- acc_err  out  1  one-cycle pulse for an out-of-range access.
- ram_addr  out  ADDR_MSB+1  RAM word address.
- ram_cen  out  1  RAM chip enable, active low.
- ram_wen  out  2  RAM write enable, active low; ram_wen = ~we of the winner.
- ram_din  out  16  RAM write data.
- ram_dout  in  16  RAM read data; valid the cycle after a read with ram_cen low.

Behaviour:
- Reset values: cpu_rvalid=0, dma_rvalid=0, acc_err=0, wait_cnt=0, rd_owner=none. While reset_n is low, ram_cen=1 and both grants are 0.
- Arbitration is combinational each cycle:
  - DMA wins if dma_req is high and (cpu_req is low, or wait_cnt==DMA_MAX_WAIT).
  - Otherwise the CPU wins if cpu_req is high.
  - Exactly one gnt is high when any request is present; none otherwise.
- wait_cnt (registered, saturating at DMA_MAX_WAIT):
  - increments when dma_req is high and DMA is not granted;
  - clears on a DMA grant or when dma_req is low.
- Address decode for the winner: off = addr - RAM_BASE; in_range = (addr >= RAM_BASE) and (off < MEM_SIZE); ram_addr = off[ADDR_MSB+1:1].
- In-range access: ram_cen=0, ram_wen=~we, ram_din=winner wdata.
- Out-of-range access:
  - still granted, so the master never hangs;
  - ram_cen=1, so the RAM is untouched;
  - acc_err pulses high in the next cycle;
  - a read returns 16'h0000 with rvalid.
- No winner: ram_cen=1, ram_wen=2'b11, ram_addr and ram_din hold the CPU-side values (don't care).
- Read return:
  - A granted read (we==00) registers owner and in_range.
  - Next cycle, the owner's rvalid=1 for exactly one cycle.
  - Owner's rdata = ram_dout if in range, else 0. The non-owner's rdata=0.
- Writes produce no rvalid. Read/write latency is 0 cycles to grant and 1 cycle to rdata.
- Back-to-back reads, with either master and alternating owners, sustain one access per cycle. Each rvalid is routed by the owner registered for that access.
- Partial write (we=01 or 10): forwarded unmodified as ram_wen=10 or 01; the RAM performs the byte merge.
- Reset asserted mid-operation: pending rvalid and acc_err clear immediately; the returned read data is lost.

Decomposition:
- Shared package pu_msp430_ram_pkg holds:
  - typedef owner_t {OWN_NONE, OWN_CPU, OWN_DMA};
  - localparam WE_READ=2'b00;
  - a function for in-range / word-address computation.
- One sub-module, pu_msp430_ram_arb_core, holds the grant logic and wait_cnt. The top level holds decode, muxing and the read-return pipeline.

Test Plan:
- CPU alone: write 16'hA5C3 to 16'h0204 (we=11), then read 16'h0204. Required: ram_addr=2, ram_wen=00 then 11, cpu_rvalid one cycle after grant, cpu_rdata=16'hA5C3.
- Byte write: we=10, data 16'h1100 at 16'h0204 over 16'hA5C3, then read. Required: ram_wen=01, read returns 16'h11C3.
- Contention, DMA_MAX_WAIT=3: cpu_req and dma_req held high continuously. Required: CPU granted 3 cycles, DMA the 4th, pattern repeating; wait_cnt never exceeds 3.
- Out-of-range: CPU read 16'h0300 (MEM_SIZE=256). Required: cpu_gnt=1, ram_cen=1, next cycle acc_err=1, cpu_rvalid=1, cpu_rdata=0. Repeat at 16'h01FE, same result.
- Interleaved reads: CPU read at 0x0200, then DMA read at 0x0202 in consecutive cycles. Required: cpu_rvalid in cycle 2, dma_rvalid in cycle 3, each with the correct data and no cross-delivery.
- Reset mid-read: assert reset_n=0 in the cycle after a grant. Required: cpu_rvalid=0 immediately, ram_cen=1; after release, a clean read works.
